// File: rtl/sbox_pkg.sv
// -----------------------------------------------------------------------------
// sbox_pkg
// Shared definitions for the RC4 S-box storage block.
//   - sbox_state_e : controller FSM states
//   - SBOX_ADDR_W  : default index width (256-entry S-box)
//   - SBOX_DATA_W  : default entry width
// -----------------------------------------------------------------------------
package sbox_pkg;

    localparam int SBOX_ADDR_W = 8;
    localparam int SBOX_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SWAP_RD = 2'd2,
        ST_SWAP_WR = 2'd3
    } sbox_state_e;

endpackage : sbox_pkg

// File: rtl/sbox_mem_array.sv
// -----------------------------------------------------------------------------
// sbox_mem_array
// DEPTH x DATA_W register array with two synchronous write ports and three
// combinational read ports. Contents are never reset.
//   clk              : write clock (rising edge)
//   we_a/addr_a/data_a : write port A (wins on an address collision)
//   we_b/addr_b/data_b : write port B
//   raddr_i/rdata_i  : read port i
//   raddr_j/rdata_j  : read port j
//   raddr_r/rdata_r  : read port for the keystream lookup path
// -----------------------------------------------------------------------------
module sbox_mem_array
    import sbox_pkg::*;
#(
    parameter int ADDR_W = SBOX_ADDR_W,
    parameter int DATA_W = SBOX_DATA_W
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_i,
    input  logic [ADDR_W-1:0] raddr_j,
    output logic [DATA_W-1:0] rdata_j,
    input  logic [ADDR_W-1:0] raddr_r,
    output logic [DATA_W-1:0] rdata_r
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array update: port B first so that port A overrides it on a collision.
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem_r[addr_b] <= data_b;
        end
        if (we_a) begin
            mem_r[addr_a] <= data_a;
        end
    end

    assign rdata_i = mem_r[raddr_i];
    assign rdata_j = mem_r[raddr_j];
    assign rdata_r = mem_r[raddr_r];

endmodule : sbox_mem_array

// File: rtl/sbox_swap_ram.sv
// -----------------------------------------------------------------------------
// sbox_swap_ram
// RC4 S-box storage. Self-initialises to the identity permutation, performs
// atomic S[i]<->S[j] swaps under a valid/ready handshake, accepts direct
// writes for key/test loading and provides a registered read port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   init_start / init_done: re-initialise request / permutation valid flag
//   swap_valid/swap_ready : swap handshake, indices swap_i / swap_j
//   swap_done             : one-cycle pulse when a swap has been committed
//   swap_si / swap_sj     : pre-swap S[i] / S[j], held until next swap_done
//   wr_en/wr_addr/wr_data : direct write, wr_ack pulses the cycle after
//   rd_addr / rd_data     : read address sampled every edge / registered data
// -----------------------------------------------------------------------------
module sbox_swap_ram
    import sbox_pkg::*;
#(
    parameter int ADDR_W = SBOX_ADDR_W,
    parameter int DATA_W = SBOX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_done,
    input  logic              swap_valid,
    output logic              swap_ready,
    input  logic [ADDR_W-1:0] swap_i,
    input  logic [ADDR_W-1:0] swap_j,
    output logic              swap_done,
    output logic [DATA_W-1:0] swap_si,
    output logic [DATA_W-1:0] swap_sj,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // The identity fill stores an index in every entry, so entries must be
    // at least as wide as an index.
    if (DATA_W < ADDR_W) begin : g_width_check
        $error("sbox_swap_ram: DATA_W must be >= ADDR_W");
    end

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    sbox_state_e       state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] idx_i_r;
    logic [ADDR_W-1:0] idx_j_r;
    logic              init_done_r;
    logic              swap_ready_r;
    logic              swap_done_r;
    logic              wr_ack_r;
    logic [DATA_W-1:0] swap_si_r;
    logic [DATA_W-1:0] swap_sj_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              init_acc_s;
    logic              swap_acc_s;
    logic              wr_acc_s;
    logic              we_a_s;
    logic [ADDR_W-1:0] addr_a_s;
    logic [DATA_W-1:0] data_a_s;
    logic              we_b_s;
    logic [ADDR_W-1:0] addr_b_s;
    logic [DATA_W-1:0] data_b_s;
    logic [DATA_W-1:0] mem_si_s;
    logic [DATA_W-1:0] mem_sj_s;
    logic [DATA_W-1:0] mem_rd_s;

    // IDLE request arbitration: init_start > swap_valid > wr_en.
    always_comb begin
        init_acc_s = 1'b0;
        swap_acc_s = 1'b0;
        wr_acc_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (init_start) begin
                init_acc_s = 1'b1;
            end else if (swap_valid && swap_ready_r) begin
                swap_acc_s = 1'b1;
            end else if (wr_en) begin
                wr_acc_s = 1'b1;
            end else begin
                wr_acc_s = 1'b0;
            end
        end else begin
            init_acc_s = 1'b0;
        end
    end

    // Write-port steering: identity fill, direct write, or the swap commit
    // which writes both entries on the same edge.
    always_comb begin
        we_a_s   = 1'b0;
        addr_a_s = cnt_r;
        data_a_s = DATA_W'(cnt_r);
        we_b_s   = 1'b0;
        addr_b_s = idx_j_r;
        data_b_s = swap_si_r;
        case (state_r)
            ST_INIT: begin
                we_a_s = 1'b1;
            end
            ST_IDLE: begin
                if (wr_acc_s) begin
                    we_a_s   = 1'b1;
                    addr_a_s = wr_addr;
                    data_a_s = wr_data;
                end else begin
                    we_a_s = 1'b0;
                end
            end
            ST_SWAP_WR: begin
                we_a_s   = 1'b1;
                addr_a_s = idx_i_r;
                data_a_s = swap_sj_r;
                we_b_s   = 1'b1;
            end
            default: begin
                we_a_s = 1'b0;
                we_b_s = 1'b0;
            end
        endcase
    end

    sbox_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_a    (we_a_s),
        .addr_a  (addr_a_s),
        .data_a  (data_a_s),
        .we_b    (we_b_s),
        .addr_b  (addr_b_s),
        .data_b  (data_b_s),
        .raddr_i (idx_i_r),
        .rdata_i (mem_si_s),
        .raddr_j (idx_j_r),
        .rdata_j (mem_sj_s),
        .raddr_r (rd_addr),
        .rdata_r (mem_rd_s)
    );

    // Control FSM, init counter, handshake flags and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            cnt_r        <= '0;
            idx_i_r      <= '0;
            idx_j_r      <= '0;
            init_done_r  <= 1'b0;
            swap_ready_r <= 1'b0;
            swap_done_r  <= 1'b0;
            wr_ack_r     <= 1'b0;
            swap_si_r    <= '0;
            swap_sj_r    <= '0;
            rd_data_r    <= '0;
        end else begin
            swap_done_r <= 1'b0;
            wr_ack_r    <= 1'b0;
            // Read port runs in every state; a same-edge write shows next read.
            rd_data_r   <= mem_rd_s;
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r      <= ST_IDLE;
                        init_done_r  <= 1'b1;
                        swap_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (init_acc_s) begin
                        cnt_r        <= '0;
                        state_r      <= ST_INIT;
                        init_done_r  <= 1'b0;
                        swap_ready_r <= 1'b0;
                    end else if (swap_acc_s) begin
                        idx_i_r      <= swap_i;
                        idx_j_r      <= swap_j;
                        state_r      <= ST_SWAP_RD;
                        swap_ready_r <= 1'b0;
                    end else if (wr_acc_s) begin
                        wr_ack_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SWAP_RD: begin
                    swap_si_r <= mem_si_s;
                    swap_sj_r <= mem_sj_s;
                    state_r   <= ST_SWAP_WR;
                end
                ST_SWAP_WR: begin
                    state_r      <= ST_IDLE;
                    swap_done_r  <= 1'b1;
                    swap_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_INIT;
                    cnt_r        <= '0;
                    init_done_r  <= 1'b0;
                    swap_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign init_done  = init_done_r;
    assign swap_ready = swap_ready_r;
    assign swap_done  = swap_done_r;
    assign wr_ack     = wr_ack_r;
    assign swap_si    = swap_si_r;
    assign swap_sj    = swap_sj_r;
    assign rd_data    = rd_data_r;

endmodule : sbox_swap_ram
